// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD requester and its surroundings.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } gcd_state_t;

    localparam int GCD_WIDTH       = 16;
    localparam int GCD_TIMEOUT_DEF = 65536;

endpackage

// File: rtl/gcd_requester.sv
// Initiator-side sequencer for the subtractive GCD core: takes operand pairs on a
// valid/ready request channel, loads the core, waits for its done flag (or a
// timeout) and returns result, iteration count and error on a response channel.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = GCD_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_z,
    output logic [WIDTH:0]   resp_cycles,
    output logic             resp_err,

    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    output logic             gcd_e,
    input  logic [WIDTH-1:0] gcd_z,
    input  logic             gcd_v
);

    localparam logic [WIDTH:0] TIMEOUT_CNT = (WIDTH + 1)'(TIMEOUT);

    gcd_state_t       state;
    gcd_state_t       state_next;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   cnt;

    // The core's load port simply mirrors the captured operands; it only
    // looks at them while gcd_e is high.
    assign gcd_a = opa;
    assign gcd_b = opb;

    // Next-state decode and handshake/strobe outputs; reset masks the strobes
    // combinationally so nothing leaks out during the reset cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        gcd_e      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = LOAD;
            end
            LOAD: begin
                gcd_e      = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (gcd_v || cnt == TIMEOUT_CNT) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            gcd_e      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Operand capture, RUN counter and registered response fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            opa         <= '0;
            opb         <= '0;
            cnt         <= '0;
            resp_z      <= '0;
            resp_cycles <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // The core never finishes for x==0, y!=0; moving B
                        // into x makes it finish immediately with z=B.
                        if (req_a == '0) begin
                            opa <= req_b;
                            opb <= '0;
                        end else begin
                            opa <= req_a;
                            opb <= req_b;
                        end
                    end
                end
                LOAD: begin
                    cnt <= '0;
                end
                RUN: begin
                    // Done has priority over timeout when both hit together.
                    if (gcd_v) begin
                        resp_z      <= gcd_z;
                        resp_cycles <= cnt;
                        resp_err    <= 1'b0;
                    end else if (cnt == TIMEOUT_CNT) begin
                        resp_z      <= '0;
                        resp_cycles <= cnt;
                        resp_err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester: two instances (default timeout and
// TIMEOUT=4), each beside a behavioural subtractive GCD core, checked against
// a Euclid-based reference model.
`timescale 1ns/1ps
module tb_gcd_requester;

    localparam int W    = 16;
    localparam int TO_0 = 65536;
    localparam int TO_1 = 4;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [15:0] req_a       [2];
    logic [15:0] req_b       [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [15:0] resp_z      [2];
    logic [16:0] resp_cycles [2];
    logic        resp_err    [2];
    logic [15:0] gcd_a       [2];
    logic [15:0] gcd_b       [2];
    logic        gcd_e       [2];
    logic [15:0] gcd_z       [2];
    logic        gcd_v       [2];

    logic [15:0] core_x [2];
    logic [15:0] core_y [2];
    int          e_count [2] = '{0, 0};

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gcd_requester #(.WIDTH(W), .TIMEOUT(TO_0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a[0]), .req_b(req_b[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_z(resp_z[0]), .resp_cycles(resp_cycles[0]), .resp_err(resp_err[0]),
        .gcd_a(gcd_a[0]), .gcd_b(gcd_b[0]), .gcd_e(gcd_e[0]),
        .gcd_z(gcd_z[0]), .gcd_v(gcd_v[0])
    );

    gcd_requester #(.WIDTH(W), .TIMEOUT(TO_1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a[1]), .req_b(req_b[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_z(resp_z[1]), .resp_cycles(resp_cycles[1]), .resp_err(resp_err[1]),
        .gcd_a(gcd_a[1]), .gcd_b(gcd_b[1]), .gcd_e(gcd_e[1]),
        .gcd_z(gcd_z[1]), .gcd_v(gcd_v[1])
    );

    // Behavioural subtractive GCD core (no reset): load on io_e, then subtract.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (gcd_e[i]) begin
                core_x[i] <= gcd_a[i];
                core_y[i] <= gcd_b[i];
            end else if (core_y[i] != 16'd0) begin
                if (core_x[i] > core_y[i]) core_x[i] <= core_x[i] - core_y[i];
                else                       core_y[i] <= core_y[i] - core_x[i];
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_core
        assign gcd_z[g] = core_x[g];
        assign gcd_v[g] = (core_y[g] == 16'd0);
    end

    // Count load strobes seen at each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (gcd_e[i] === 1'b1) e_count[i]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: GCD via Euclid; the subtractive core spends the sum of the
    // Euclid quotients in RUN; beyond the timeout the block aborts.
    task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input int timeout,
                             output logic [15:0] z, output int k, output logic err);
        int hi, lo, r, steps;
        hi    = (a > b) ? int'(a) : int'(b);
        lo    = (a > b) ? int'(b) : int'(a);
        steps = 0;
        while (lo != 0) begin
            steps += hi / lo;
            r  = hi % lo;
            hi = lo;
            lo = r;
        end
        if (steps > timeout) begin
            z = 16'd0; k = timeout; err = 1'b1;
        end else begin
            z = 16'(hi); k = steps; err = 1'b0;
        end
    endtask

    // One full transaction on instance u, entered and left on a falling edge.
    // hold>0 keeps resp_ready low that many cycles while poking req_valid.
    task automatic txn(input int u, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input string tag);
        logic [15:0] ez;
        int          ek;
        logic        eerr;
        int          lat;
        int          e0;
        ref_model(a, b, (u == 0) ? TO_0 : TO_1, ez, ek, eerr);
        req_a[u]      = a;
        req_b[u]      = b;
        req_valid[u]  = 1'b1;
        resp_ready[u] = (hold == 0);
        lat = 0;
        while (!req_ready[u] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/req_ready"}, 32'(req_ready[u]), 32'd1);
        e0 = e_count[u];
        @(negedge clk);
        req_valid[u] = 1'b0;
        lat = 1;
        while (!resp_valid[u] && lat < ek + 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(3 + ek));
        for (int h = 0; h < hold; h++) begin
            check({tag, "/hold_z"}, 32'(resp_z[u]), 32'(ez));
            check({tag, "/hold_valid"}, 32'(resp_valid[u]), 32'd1);
            check({tag, "/hold_req_ready"}, 32'(req_ready[u]), 32'd0);
            req_valid[u] = ~req_valid[u];
            req_a[u]     = 16'($urandom);
            req_b[u]     = 16'($urandom);
            @(negedge clk);
        end
        req_valid[u]  = 1'b0;
        resp_ready[u] = 1'b1;
        check({tag, "/resp_z"}, 32'(resp_z[u]), 32'(ez));
        check({tag, "/resp_cycles"}, 32'(resp_cycles[u]), 32'(ek));
        check({tag, "/resp_err"}, 32'(resp_err[u]), 32'(eerr));
        @(negedge clk);
        check({tag, "/resp_done"}, 32'(resp_valid[u]), 32'd0);
        check({tag, "/load_pulses"}, 32'(e_count[u] - e0), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb, rz;
        int          rk, lat;
        logic        rerr;
        bit          saw_resp;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; resp_ready[i] = 1'b0;
            req_a[i] = 16'd0; req_b[i] = 16'd0;
        end
        repeat (3) @(negedge clk);
        check("rst/req_ready_forced", 32'(req_ready[0]), 32'd0);
        check("rst/gcd_e_forced", 32'(gcd_e[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst/req_ready", 32'(req_ready[0]), 32'd1);
        check("rst/resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst/resp_z", 32'(resp_z[0]), 32'd0);
        check("rst/resp_cycles", 32'(resp_cycles[0]), 32'd0);
        check("rst/resp_err", 32'(resp_err[0]), 32'd0);
        check("rst/gcd_a", 32'(gcd_a[0]), 32'd0);

        // Directed cases.
        txn(0, 16'd12, 16'd8, 0, "a12_b8");
        txn(0, 16'd7,  16'd0, 0, "a7_b0");
        txn(0, 16'd0,  16'd9, 0, "a0_b9");
        txn(0, 16'd0,  16'd0, 0, "a0_b0");
        txn(1, 16'd100, 16'd1, 0, "to_a100_b1");
        txn(1, 16'd12, 16'd8, 0, "to_a12_b8");
        txn(0, 16'd21, 16'd6, 10, "hold_a21_b6");

        // Reset in the second RUN cycle drops the transaction.
        req_a[0] = 16'd65535; req_b[0] = 16'd1; req_valid[0] = 1'b1;
        resp_ready[0] = 1'b1;
        lat = 0;
        while (!req_ready[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);                 // LOAD
        req_valid[0] = 1'b0;
        @(negedge clk);                 // RUN cycle 1
        @(negedge clk);                 // RUN cycle 2
        reset = 1'b1;
        #1;
        check("midrun/req_ready_in_reset", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        check("midrun/req_ready_idle_reset", 32'(req_ready[0]), 32'd0);
        check("midrun/resp_valid_reset", 32'(resp_valid[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrun/req_ready_after", 32'(req_ready[0]), 32'd1);
        check("midrun/resp_cycles_cleared", 32'(resp_cycles[0]), 32'd0);
        saw_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid[0]) saw_resp = 1'b1;
            @(negedge clk);
        end
        check("midrun/no_response", 32'(saw_resp), 32'd0);
        txn(0, 16'd9, 16'd6, 0, "after_rst_a9_b6");

        // Back-to-back random pairs; very long subtraction chains are redrawn
        // to keep the run short.
        for (int n = 0; n < 20; n++) begin
            do begin
                ra = 16'($urandom_range(1, 65535));
                rb = 16'($urandom_range(1, 65535));
                ref_model(ra, rb, TO_0, rz, rk, rerr);
            end while (rk > 1500);
            txn(0, ra, rb, 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
